// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and width helpers for the Sobel stream filter.
package sobel_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_MAG    = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Signed gradient width: |G| <= 4*(2^pix_w-1) plus a sign bit.
    function automatic int grad_width(input int pix_w);
        return pix_w + 4;
    endfunction

    // Unsigned |H|+|V| width: at most 8*(2^pix_w-1).
    function automatic int mag_width(input int pix_w);
        return pix_w + 3;
    endfunction

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels. The read is combinational, so the old value for a
// column is visible in the same cycle that the new value is written (read-before-write).
module sobel_line_buffer #(
    parameter int DEPTH  = 800,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Write the column slot on every shift of the window.
    always_ff @(posedge clock) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter with frame sync, end-of-frame flush and runtime modes.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for an in_sof beat; beats without in_sof are dropped
// ST_RUN   | accepting frame pixels; in_sof here restarts the frame
// ST_FLUSH | in_ready low, IMG_W+1 zero beats push out the last line
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 10,
    parameter int IMG_W  = 800,
    parameter int IMG_H  = 600
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_sof,
    input  logic [1:0]         mode,
    input  logic [PIX_W+2:0]   threshold,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sof,
    output logic               out_eol
);

    localparam int GW = grad_width(PIX_W);
    localparam int MW = mag_width(PIX_W);
    localparam int CW = cnt_width(IMG_W - 1);
    // Flush beats run the beat row counter up to IMG_H+1.
    localparam int RW = cnt_width(IMG_H + 1);
    localparam int FW = cnt_width(IMG_W);
    localparam int SW = (MW > OUT_W) ? MW : OUT_W;

    state_t state, state_nx;

    logic [FW-1:0]    flush_cnt;
    logic [CW-1:0]    in_col, cur_col, cen_c;
    logic [RW-1:0]    in_row, cur_row, cen_r;
    logic [1:0]       mode_q;
    logic [MW-1:0]    thr_q;

    logic             accept, sof_beat, abort, run_beat, flush_beat, beat;
    logic             last_pix, centre_emit;
    logic [PIX_W-1:0] pix_in, lb1_rd, lb2_rd;
    logic [DATA_W-PIX_W-1:0] unused_lsbs;

    logic [PIX_W-1:0] win [3][3];

    logic             s1_valid, s1_sof, s1_eol, s1_border;
    logic [1:0]       s1_mode;
    logic [MW-1:0]    s1_thr;

    logic             s2_valid, s2_sof, s2_eol, s2_border;
    logic [1:0]       s2_mode;
    logic [MW-1:0]    s2_thr;
    logic [PIX_W-1:0] s2_cen;
    logic signed [GW-1:0] s2_gx, s2_gy;

    logic signed [GW-1:0] ext [3][3];
    logic signed [GW-1:0] gx_c, gy_c;
    logic [MW-1:0]    abs_x, abs_y, mag;
    logic [SW-1:0]    mag_ext;
    logic [OUT_W-1:0] sat, result;

    assign in_ready    = (state != ST_FLUSH);
    assign accept      = in_valid && in_ready;
    assign sof_beat    = accept && in_sof;
    assign abort       = sof_beat && (state == ST_RUN);
    assign run_beat    = accept && !in_sof && (state == ST_RUN);
    assign flush_beat  = (state == ST_FLUSH);
    assign beat        = sof_beat || run_beat || flush_beat;

    assign pix_in      = flush_beat ? '0 : in_data[DATA_W-1 -: PIX_W];
    assign unused_lsbs = in_data[DATA_W-PIX_W-1:0];

    // An in_sof beat is always raster position (0,0), whatever the counters hold.
    assign cur_col     = sof_beat ? '0 : in_col;
    assign cur_row     = sof_beat ? '0 : in_row;
    assign last_pix    = run_beat && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    // A centre completes once the beat index reaches IMG_W+1.
    assign centre_emit = beat && ((cur_row > RW'(1)) || ((cur_row == RW'(1)) && (cur_col != '0)));

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (sof_beat)          state_nx = ST_RUN;
            ST_RUN:   if (last_pix)          state_nx = ST_FLUSH;
            ST_FLUSH: if (flush_cnt == '0)   state_nx = ST_IDLE;
            default:                         state_nx = ST_IDLE;
        endcase
    end

    // Flush down-counter: loaded with IMG_W, so FLUSH lasts IMG_W+1 clocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (last_pix) begin
            flush_cnt <= FW'(IMG_W);
        end else if (flush_beat && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - FW'(1);
        end
    end

    // Beat position, centre position and per-frame mode/threshold capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_col <= '0;
            in_row <= '0;
            cen_c  <= '0;
            cen_r  <= '0;
            mode_q <= MODE_MAG;
            thr_q  <= '0;
        end else begin
            if (beat) begin
                if (cur_col == CW'(IMG_W - 1)) begin
                    in_col <= '0;
                    in_row <= cur_row + RW'(1);
                end else begin
                    in_col <= cur_col + CW'(1);
                    in_row <= cur_row;
                end
            end
            if (sof_beat) begin
                cen_c  <= '0;
                cen_r  <= '0;
                mode_q <= mode;
                thr_q  <= threshold;
            end else if (centre_emit) begin
                if (cen_c == CW'(IMG_W - 1)) begin
                    cen_c <= '0;
                    cen_r <= cen_r + RW'(1);
                end else begin
                    cen_c <= cen_c + CW'(1);
                end
            end
        end
    end

    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .PIX_W  (PIX_W),
        .ADDR_W (CW)
    ) u_line_r1 (
        .clock (clock),
        .en    (beat),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .PIX_W  (PIX_W),
        .ADDR_W (CW)
    ) u_line_r2 (
        .clock (clock),
        .en    (beat),
        .addr  (cur_col),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    // 3x3 window: column 2 is the newest, row 2 the current line.
    always_ff @(posedge clock) begin
        if (beat) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= pix_in;
        end
    end

    // Stage 1: tag the centre that the window completes on this beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_border <= 1'b0;
            s1_mode   <= MODE_MAG;
            s1_thr    <= '0;
        end else begin
            s1_valid  <= centre_emit;
            s1_sof    <= (cen_r == '0) && (cen_c == '0);
            s1_eol    <= (cen_c == CW'(IMG_W - 1));
            s1_border <= (cen_r == '0) || (cen_r == RW'(IMG_H - 1)) ||
                         (cen_c == '0) || (cen_c == CW'(IMG_W - 1));
            s1_mode   <= mode_q;
            s1_thr    <= thr_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ext[i][j] = $signed(GW'(win[i][j]));
            end
        end
        gx_c = (ext[0][2] + (ext[1][2] <<< 1) + ext[2][2]) -
               (ext[0][0] + (ext[1][0] <<< 1) + ext[2][0]);
        gy_c = (ext[2][0] + (ext[2][1] <<< 1) + ext[2][2]) -
               (ext[0][0] + (ext[0][1] <<< 1) + ext[0][2]);
    end

    // Stage 2: horizontal and vertical gradients; an abort squashes the stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eol    <= 1'b0;
            s2_border <= 1'b0;
            s2_mode   <= MODE_MAG;
            s2_thr    <= '0;
            s2_cen    <= '0;
            s2_gx     <= '0;
            s2_gy     <= '0;
        end else begin
            s2_valid  <= s1_valid && !abort;
            s2_sof    <= s1_sof;
            s2_eol    <= s1_eol;
            s2_border <= s1_border;
            s2_mode   <= s1_mode;
            s2_thr    <= s1_thr;
            s2_cen    <= win[1][1];
            s2_gx     <= gx_c;
            s2_gy     <= gy_c;
        end
    end

    // Magnitude, saturation and mode selection; mode 3 falls through to magnitude.
    always_comb begin
        abs_x   = s2_gx[GW-1] ? MW'(-s2_gx) : MW'(s2_gx);
        abs_y   = s2_gy[GW-1] ? MW'(-s2_gy) : MW'(s2_gy);
        mag     = abs_x + abs_y;
        mag_ext = SW'(mag);
        sat     = (mag_ext > SW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : OUT_W'(mag_ext);
        result  = '0;
        case (s2_mode)
            MODE_BYPASS: result = OUT_W'(s2_cen) << (OUT_W - PIX_W);
            MODE_THRESH: result = (!s2_border && (mag >= s2_thr)) ? {OUT_W{1'b1}} : '0;
            default:     result = s2_border ? '0 : sat;
        endcase
    end

    // Stage 3: registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= s2_valid && !abort;
            out_data  <= (s2_valid && !abort) ? result : '0;
            out_sof   <= s2_valid && !abort && s2_sof;
            out_eol   <= s2_valid && !abort && s2_eol;
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter on an 8x6 image.
module tb_sobel_stream_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [9:0]  in_data = '0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] threshold = '0;
    logic        in_ready;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        out_sof;
    logic        out_eol;

    int          n_checks = 0;
    int          n_pass = 0;
    int          ready_low = 0;
    logic [11:0] q[$];
    logic [9:0]  fdata [N];

    always #5 clock = ~clock;

    sobel_stream_filter #(
        .DATA_W (10),
        .PIX_W  (8),
        .OUT_W  (10),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .mode      (mode),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    // Output capture and in_ready-low accounting, away from the active edge.
    always @(negedge clock) begin
        if (!reset && out_valid) q.push_back({out_data, out_sof, out_eol});
        if (!in_ready) ready_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] got(input int i);
        if (i < q.size()) return q[i];
        return 12'hxxx;
    endfunction

    // Reference: Sobel on the image held in fdata, straight from the definition.
    function automatic logic [11:0] model(input int r, input int c, input int md, input int thr);
        int p [3][3];
        int gx, gy, mag, val;
        bit border;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int rr, cc;
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) p[dr][dc] = int'(fdata[rr*W+cc]) / 4;
                else p[dr][dc] = 0;
            end
        end
        border = (r == 0) || (r == H-1) || (c == 0) || (c == W-1);
        if (md == 0) val = p[1][1] * 4;
        else if (border) val = 0;
        else begin
            gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
            gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (md == 2) val = (mag >= thr) ? 1023 : 0;
            else val = (mag > 1023) ? 1023 : mag;
        end
        return {10'(val), (r == 0 && c == 0), (c == W-1)};
    endfunction

    task automatic push(input logic [9:0] d, input logic sof);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!in_ready) begin
            $display("FAIL push_timeout: in_ready observed 0 required 1");
            $fatal(1, "bench stopped");
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Send fdata as one frame; mode/threshold are scrambled after the sof beat
    // because the block must hold the values it sampled.
    task automatic run_frame(input int md, input int thr, input bit gaps, input string tag);
        int n;
        mode      = 2'(md);
        threshold = 11'(thr);
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                n = $urandom_range(0, 3);
                repeat (n) begin @(posedge clock); #1; end
            end
            push(fdata[i], (i == 0));
            if (i == 0) begin
                q.delete();
                ready_low = 0;
                mode      = 2'($urandom_range(0, 3));
                threshold = 11'($urandom_range(0, 2047));
            end
        end
        for (int k = 0; k < 400 && q.size() < N; k++) @(posedge clock);
        repeat (12) @(posedge clock);
        #1;
        check($sformatf("%s_count", tag), q.size(), N);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_px%0d", tag, i), got(i), model(i / W, i % W, md, thr));
        check($sformatf("%s_ready_low", tag), ready_low, W + 1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eol", out_eol, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // Reset mid-frame, then a stray non-sof beat that IDLE must drop.
        mode = 2'd1;
        for (int i = 0; i < 20; i++) push(10'($urandom_range(0, 1023)), (i == 0));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t1_out_valid", out_valid, 0);
        check("t1_in_ready", in_ready, 1);
        q.delete();
        push(10'h155, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        check("t1_dropped", q.size(), 0);
        for (int i = 0; i < N; i++) fdata[i] = 10'($urandom_range(0, 1023));
        run_frame(1, 0, 1'b0, "t1_frame");

        // Flat frame.
        for (int i = 0; i < N; i++) fdata[i] = 10'h200;
        run_frame(1, 0, 1'b0, "t2_flat");

        // Vertical step.
        for (int i = 0; i < N; i++) fdata[i] = (i % W < 4) ? 10'h000 : 10'h3FC;
        run_frame(1, 0, 1'b0, "t3_step");
        check("t3_r1c3", got(1*W+3), {10'd1020, 2'b00});
        check("t3_r2c4", got(2*W+4), {10'd1020, 2'b00});
        run_frame(2, 500, 1'b0, "t4_thresh");
        check("t4_r4c3", got(4*W+3), {10'd1023, 2'b00});

        // Single bright pixel.
        for (int i = 0; i < N; i++) fdata[i] = 10'h000;
        fdata[2*W+2] = 10'h3FC;
        run_frame(1, 0, 1'b0, "t5_dot");
        check("t5_r1c1", got(1*W+1), {10'd510, 2'b00});
        check("t5_r2c2", got(2*W+2), {10'd0, 2'b00});

        // Bypass ramp with input gaps.
        for (int i = 0; i < N; i++) fdata[i] = 10'(i << 2);
        run_frame(0, 0, 1'b1, "t6_ramp");
        check("t6_last", got(N-1), {10'(47 << 2), 2'b01});

        // Abort after 20 pixels; the restarted frame must come out whole.
        mode = 2'd1;
        for (int i = 0; i < 20; i++) push(10'($urandom_range(0, 1023)), (i == 0));
        for (int i = 0; i < N; i++) fdata[i] = 10'($urandom_range(0, 1023));
        run_frame(1, 0, 1'b0, "t6_abort");

        // Random frames in random modes.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) fdata[i] = 10'($urandom_range(0, 1023));
            run_frame($urandom_range(0, 3), $urandom_range(0, 2047), 1'b1, $sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
